// File: rtl/mem_responder.sv
// Handshaked 512 x 32 word memory responder for a simple datapath MAR/MDR pair.
// A request is latched in IDLE, and then takes one wait cycle and one access cycle. Done/Err then pulse for one cycle.
module mem_responder (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Data_in,
  output logic [31:0] Mdatain,
  output logic        Done,
  output logic        Err
);

  localparam int DEPTH  = 512;
  localparam int AWIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCEPT  = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_RESP    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t              state_r;
  logic [AWIDTH-1:0]   addr_r;
  logic [31:0]         data_r;
  logic                is_write_r;
  logic                err_flag_r;
  logic [31:0]         mdatain_r;
  logic                done_r;
  logic                err_r;
  logic [31:0]         mem_r [0:DEPTH-1];

  logic                req_s;
  logic                reject_s;
  logic                mem_we_s;

  // Request decode: both strobes together or any address bit above the array is a reject.
  always_comb begin
    req_s    = Read | Write;
    reject_s = (Read & Write) | (|Address[31:AWIDTH]);
    mem_we_s = (state_r == ST_ACCESS) && is_write_r && !err_flag_r;
  end

  // Storage array; deliberately outside the reset domain so clear preserves contents.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem_r[addr_r] <= data_r;
    end
  end

  // Transaction FSM with registered Done/Err/Mdatain.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_r    <= ST_IDLE;
      addr_r     <= 9'd0;
      data_r     <= 32'h0000_0000;
      is_write_r <= 1'b0;
      err_flag_r <= 1'b0;
      mdatain_r  <= 32'h0000_0000;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            if (reject_s) begin
              err_flag_r <= 1'b1;
              done_r     <= 1'b1;
              err_r      <= 1'b1;
              state_r    <= ST_RESP;
            end else begin
              addr_r     <= Address[AWIDTH-1:0];
              data_r     <= Data_in;
              is_write_r <= Write;
              err_flag_r <= 1'b0;
              state_r    <= ST_ACCEPT;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCEPT: begin
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // Done/Err are set here so they are high exactly while in RESP.
          if (!is_write_r) begin
            mdatain_r <= mem_r[addr_r];
          end else begin
            mdatain_r <= mdatain_r;
          end
          done_r  <= 1'b1;
          err_r   <= err_flag_r;
          state_r <= ST_RESP;
        end
        ST_RESP: begin
          state_r <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!Read && !Write) begin
            err_flag_r <= 1'b0;
            state_r    <= ST_IDLE;
          end else begin
            state_r <= ST_RELEASE;
          end
        end
        default: begin
          err_flag_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign Mdatain = mdatain_r;
  assign Done    = done_r;
  assign Err     = err_r;

endmodule
